alu_mc: RTL and testbench

Parametrised multi-cycle ALU for the pipelined MIPS32 execute stage, successor to the single-cycle registered ALU. Executes logic, add/sub, compare and shift ops in one cycle, and unsigned multiply/divide/remainder iteratively over WIDTH cycles. Operands enter and results leave through valid/ready handshakes, so the pipeline control can stall EX while a long op is in flight. All outputs are registered.

---
 rtl/alu_mc_pkg.sv | 31 +++
 rtl/alu_iter_muldiv.sv | 100 ++++++++++
 rtl/alu_mc.sv | 172 +++++++++++++++++
 tb/tb_alu_mc.sv | 298 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/alu_mc_pkg.sv
// Shared types for the multi-cycle MIPS32 execute-stage ALU: op codes, FSM states
// and the helper that separates iterative ops from single-cycle ones.
package alu_mc_pkg;

    typedef enum logic [3:0] {
        OP_AND  = 4'b0000,
        OP_OR   = 4'b0001,
        OP_ADD  = 4'b0010,
        OP_SLL  = 4'b0011,
        OP_SRL  = 4'b0100,
        OP_SRA  = 4'b0101,
        OP_SUB  = 4'b0110,
        OP_SLT  = 4'b0111,
        OP_MULU = 4'b1000,
        OP_DIVU = 4'b1001,
        OP_REMU = 4'b1010,
        OP_NOR  = 4'b1100,
        OP_SLTU = 4'b1111
    } alu_op_e;

    typedef enum logic [1:0] {
        IDLE,
        BUSY,
        DONE
    } alu_state_e;

    function automatic logic is_iterative(input logic [3:0] op);
        return (op == OP_MULU) || (op == OP_DIVU) || (op == OP_REMU);
    endfunction

endpackage

// File: rtl/alu_iter_muldiv.sv
// Iterative unsigned multiply (shift-add) and restoring divide, one step per cycle
// over WIDTH cycles; done pulses for one cycle once the final step has landed.
module alu_iter_muldiv #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             start,
    input  logic             is_div,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] product_lo,
    output logic [WIDTH-1:0] quotient,
    output logic [WIDTH-1:0] remainder
);

    localparam int CW = $clog2(WIDTH);

    // x holds multiplier / dividend-becoming-quotient, y the multiplicand / divisor,
    // acc the running product or partial remainder.
    logic [WIDTH-1:0] x_q, x_d;
    logic [WIDTH-1:0] y_q, y_d;
    logic [WIDTH-1:0] acc_q, acc_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;
    logic             is_div_q, is_div_d;
    logic [WIDTH:0]   rem_sh;
    logic [WIDTH:0]   rem_diff;

    always_comb begin
        x_d      = x_q;
        y_d      = y_q;
        acc_d    = acc_q;
        cnt_d    = cnt_q;
        busy_d   = busy_q;
        done_d   = 1'b0;
        is_div_d = is_div_q;
        rem_sh   = {acc_q, x_q[WIDTH-1]};
        rem_diff = rem_sh - {1'b0, y_q};

        if (start) begin
            x_d      = a;
            y_d      = b;
            acc_d    = '0;
            cnt_d    = CW'(WIDTH - 1);
            busy_d   = 1'b1;
            is_div_d = is_div;
        end else if (busy_q) begin
            if (is_div_q) begin
                if (!rem_diff[WIDTH]) begin
                    acc_d = rem_diff[WIDTH-1:0];
                    x_d   = {x_q[WIDTH-2:0], 1'b1};
                end else begin
                    acc_d = rem_sh[WIDTH-1:0];
                    x_d   = {x_q[WIDTH-2:0], 1'b0};
                end
            end else begin
                acc_d = acc_q + (x_q[0] ? y_q : '0);
                x_d   = x_q >> 1;
                y_d   = y_q << 1;
            end
            if (cnt_q == '0) begin
                busy_d = 1'b0;
                done_d = 1'b1;
            end else begin
                cnt_d = cnt_q - 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            x_q      <= '0;
            y_q      <= '0;
            acc_q    <= '0;
            cnt_q    <= '0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            is_div_q <= 1'b0;
        end else begin
            x_q      <= x_d;
            y_q      <= y_d;
            acc_q    <= acc_d;
            cnt_q    <= cnt_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
            is_div_q <= is_div_d;
        end
    end

    assign busy       = busy_q;
    assign done       = done_q;
    assign product_lo = acc_q;
    assign quotient   = x_q;
    assign remainder  = acc_q;

endmodule

// File: rtl/alu_mc.sv
// Multi-cycle ALU for the MIPS32 EX stage: single-cycle logic/arith/shift ops plus
// iterative MULU/DIVU/REMU, with valid/ready handshakes on both sides.
module alu_mc #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [3:0]       alu_ctrl,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] result,
    output logic             zero,
    output logic             overflow
);
    import alu_mc_pkg::*;

    localparam int SHW = $clog2(WIDTH);

    alu_state_e       state_q, state_d;
    logic [WIDTH-1:0] result_q, result_d;
    logic             zero_q, zero_d;
    logic             overflow_q, overflow_d;
    logic             out_valid_q, out_valid_d;
    alu_op_e          op_q, op_d;
    logic [WIDTH-1:0] a_q, a_d;
    logic             b_zero_q, b_zero_d;

    logic             accept;
    logic             md_start;
    logic             md_busy;
    logic             md_done;
    logic [WIDTH-1:0] md_product;
    logic [WIDTH-1:0] md_quotient;
    logic [WIDTH-1:0] md_remainder;
    logic [WIDTH-1:0] sc_result;
    logic             sc_overflow;
    logic [WIDTH-1:0] sum;
    logic [WIDTH-1:0] diff;
    logic [SHW-1:0]   shamt;
    logic [WIDTH-1:0] iter_result;

    assign in_ready = (state_q == IDLE) || ((state_q == DONE) && out_ready);
    assign accept   = in_valid && in_ready;

    // Unknown op codes fall through to ADD, including its overflow rule.
    always_comb begin
        sum         = a + b;
        diff        = a - b;
        shamt       = b[SHW-1:0];
        sc_overflow = 1'b0;
        case (alu_ctrl)
            OP_AND:  sc_result = a & b;
            OP_OR:   sc_result = a | b;
            OP_NOR:  sc_result = ~(a | b);
            OP_SLL:  sc_result = a << shamt;
            OP_SRL:  sc_result = a >> shamt;
            OP_SRA:  sc_result = $unsigned($signed(a) >>> shamt);
            OP_SLT:  sc_result = {{(WIDTH-1){1'b0}}, ($signed(a) < $signed(b))};
            OP_SLTU: sc_result = {{(WIDTH-1){1'b0}}, (a < b)};
            OP_SUB: begin
                sc_result   = diff;
                sc_overflow = (a[WIDTH-1] != b[WIDTH-1]) && (diff[WIDTH-1] != a[WIDTH-1]);
            end
            default: begin
                sc_result   = sum;
                sc_overflow = (a[WIDTH-1] == b[WIDTH-1]) && (sum[WIDTH-1] != a[WIDTH-1]);
            end
        endcase
    end

    always_comb begin
        iter_result = md_product;
        if (op_q == OP_DIVU) begin
            iter_result = b_zero_q ? '1 : md_quotient;
        end else if (op_q == OP_REMU) begin
            iter_result = b_zero_q ? a_q : md_remainder;
        end
    end

    always_comb begin
        state_d     = state_q;
        result_d    = result_q;
        zero_d      = zero_q;
        overflow_d  = overflow_q;
        out_valid_d = out_valid_q;
        op_d        = op_q;
        a_d         = a_q;
        b_zero_d    = b_zero_q;
        md_start    = 1'b0;

        case (state_q)
            IDLE, DONE: begin
                if ((state_q == DONE) && out_ready) begin
                    state_d     = IDLE;
                    out_valid_d = 1'b0;
                end
                if (accept) begin
                    if (is_iterative(alu_ctrl)) begin
                        state_d     = BUSY;
                        out_valid_d = 1'b0;
                        md_start    = 1'b1;
                        op_d        = alu_op_e'(alu_ctrl);
                        a_d         = a;
                        b_zero_d    = (b == '0);
                    end else begin
                        state_d     = DONE;
                        out_valid_d = 1'b1;
                        result_d    = sc_result;
                        zero_d      = (sc_result == '0);
                        overflow_d  = sc_overflow;
                    end
                end
            end
            BUSY: begin
                if (md_done && !md_busy) begin
                    state_d     = DONE;
                    out_valid_d = 1'b1;
                    result_d    = iter_result;
                    zero_d      = (iter_result == '0);
                    overflow_d  = 1'b0;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= IDLE;
            result_q    <= '0;
            zero_q      <= 1'b0;
            overflow_q  <= 1'b0;
            out_valid_q <= 1'b0;
            op_q        <= OP_ADD;
            a_q         <= '0;
            b_zero_q    <= 1'b0;
        end else begin
            state_q     <= state_d;
            result_q    <= result_d;
            zero_q      <= zero_d;
            overflow_q  <= overflow_d;
            out_valid_q <= out_valid_d;
            op_q        <= op_d;
            a_q         <= a_d;
            b_zero_q    <= b_zero_d;
        end
    end

    alu_iter_muldiv #(.WIDTH(WIDTH)) u_muldiv (
        .clk        (clk),
        .reset_n    (reset_n),
        .start      (md_start),
        .is_div     (alu_ctrl != OP_MULU),
        .a          (a),
        .b          (b),
        .busy       (md_busy),
        .done       (md_done),
        .product_lo (md_product),
        .quotient   (md_quotient),
        .remainder  (md_remainder)
    );

    assign result    = result_q;
    assign zero      = zero_q;
    assign overflow  = overflow_q;
    assign out_valid = out_valid_q;

endmodule

// File: tb/tb_alu_mc.sv
// Directed self-checking bench for alu_mc at WIDTH=32, with a second WIDTH=8 instance
// for the narrow-width regression vectors.
module tb_alu_mc;
    import alu_mc_pkg::*;

    logic        clk = 1'b0;
    logic        reset_n;

    logic        in_valid;
    logic        in_ready;
    logic [31:0] a;
    logic [31:0] b;
    logic [3:0]  alu_ctrl;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] result;
    logic        zero;
    logic        overflow;

    logic        in_valid8;
    logic        in_ready8;
    logic [7:0]  a8;
    logic [7:0]  b8;
    logic [3:0]  alu_ctrl8;
    logic        out_valid8;
    logic        out_ready8;
    logic [7:0]  result8;
    logic        zero8;
    logic        overflow8;

    int          errors = 0;
    int          checks = 0;
    int          lat;
    logic        rdy_seen;
    logic        stale;

    logic [31:0] sa [4];
    logic [31:0] sb [4];
    logic [31:0] se [4];

    always #5 clk = ~clk;

    alu_mc #(.WIDTH(32)) dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .alu_ctrl  (alu_ctrl),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .result    (result),
        .zero      (zero),
        .overflow  (overflow)
    );

    alu_mc #(.WIDTH(8)) dut8 (
        .clk       (clk),
        .reset_n   (reset_n),
        .in_valid  (in_valid8),
        .in_ready  (in_ready8),
        .a         (a8),
        .b         (b8),
        .alu_ctrl  (alu_ctrl8),
        .out_valid (out_valid8),
        .out_ready (out_ready8),
        .result    (result8),
        .zero      (zero8),
        .overflow  (overflow8)
    );

    task automatic checkOutput(input string tag, input logic [63:0] observed,
                               input logic [63:0] expected);
        checks++;
        assert (observed === expected)
        else begin
            errors++;
            $error("[TB] FAIL %s: observed=0x%0h expected=0x%0h", tag, observed, expected);
        end
    endtask

    task automatic applyStimulus(input logic [3:0] op, input logic [31:0] av,
                                 input logic [31:0] bv);
        in_valid = 1'b1;
        alu_ctrl = op;
        a        = av;
        b        = bv;
    endtask

    // Issue one op from IDLE and stop at the negedge just after the accepting edge.
    task automatic runSingle(input logic [3:0] op, input logic [31:0] av, input logic [31:0] bv);
        @(negedge clk);
        applyStimulus(op, av, bv);
        @(negedge clk);
        in_valid = 1'b0;
    endtask

    // Issue an iterative op, scramble the inputs, then count cycles until out_valid.
    task automatic runIter(input logic [3:0] op, input logic [31:0] av, input logic [31:0] bv,
                           output int latency, output logic ready_seen);
        @(negedge clk);
        applyStimulus(op, av, bv);
        @(negedge clk);
        in_valid   = 1'b0;
        a          = 32'hDEAD_BEEF;
        b          = 32'h0000_0003;
        alu_ctrl   = OP_AND;
        latency    = 0;
        ready_seen = 1'b0;
        while (!out_valid && latency < 200) begin
            if (in_ready) ready_seen = 1'b1;
            @(negedge clk);
            latency++;
        end
    endtask

    initial begin
        reset_n    = 1'b0;
        in_valid   = 1'b0;
        out_ready  = 1'b1;
        a          = '0;
        b          = '0;
        alu_ctrl   = '0;
        in_valid8  = 1'b0;
        out_ready8 = 1'b1;
        a8         = '0;
        b8         = '0;
        alu_ctrl8  = '0;

        sa = '{32'hFFFF_FFFF, 32'h1234_5678, 32'hF0F0_F0F0, 32'hAAAA_AAAA};
        sb = '{32'h0000_FFFF, 32'h0F0F_0F0F, 32'h3C3C_3C3C, 32'h5555_5555};
        se = '{32'h0000_FFFF, 32'h0204_0608, 32'h3030_3030, 32'h0000_0000};

        $display("[TB] reset");
        repeat (2) @(negedge clk);
        checkOutput("rst_out_valid", 64'(out_valid), 64'd0);
        checkOutput("rst_result", 64'(result), 64'd0);
        checkOutput("rst_zero", 64'(zero), 64'd0);
        checkOutput("rst_overflow", 64'(overflow), 64'd0);
        reset_n = 1'b1;
        @(negedge clk);
        checkOutput("rst_in_ready", 64'(in_ready), 64'd1);

        $display("[TB] single-cycle ops");
        @(negedge clk);
        applyStimulus(OP_ADD, 32'h7FFF_FFFF, 32'h0000_0001);
        checkOutput("add_pre_valid", 64'(out_valid), 64'd0);
        @(negedge clk);
        in_valid = 1'b0;
        checkOutput("add_valid", 64'(out_valid), 64'd1);
        checkOutput("add_result", 64'(result), 64'h8000_0000);
        checkOutput("add_overflow", 64'(overflow), 64'd1);
        checkOutput("add_zero", 64'(zero), 64'd0);

        runSingle(OP_SUB, 32'd5, 32'd5);
        checkOutput("sub_result", 64'(result), 64'd0);
        checkOutput("sub_zero", 64'(zero), 64'd1);
        checkOutput("sub_overflow", 64'(overflow), 64'd0);

        runSingle(OP_SUB, 32'h8000_0000, 32'h0000_0001);
        checkOutput("sub_ovf_result", 64'(result), 64'h7FFF_FFFF);
        checkOutput("sub_ovf_overflow", 64'(overflow), 64'd1);

        runSingle(OP_SLT, 32'hFFFF_FFFF, 32'd1);
        checkOutput("slt_result", 64'(result), 64'd1);
        runSingle(OP_SLTU, 32'hFFFF_FFFF, 32'd1);
        checkOutput("sltu_result", 64'(result), 64'd0);
        checkOutput("sltu_zero", 64'(zero), 64'd1);

        runSingle(OP_SRA, 32'h8000_0000, 32'd31);
        checkOutput("sra_result", 64'(result), 64'hFFFF_FFFF);
        runSingle(OP_SRL, 32'h8000_0000, 32'd31);
        checkOutput("srl_result", 64'(result), 64'd1);
        runSingle(OP_SLL, 32'h0000_0001, 32'd33);
        checkOutput("sll33_result", 64'(result), 64'd2);
        runSingle(OP_SRL, 32'h8000_0000, 32'd33);
        checkOutput("srl33_result", 64'(result), 64'h4000_0000);

        runSingle(OP_NOR, 32'h0000_0000, 32'h0000_00F0);
        checkOutput("nor_result", 64'(result), 64'hFFFF_FF0F);
        runSingle(OP_OR, 32'h0000_0F00, 32'h0000_00F0);
        checkOutput("or_result", 64'(result), 64'h0000_0FF0);
        runSingle(4'b1011, 32'd2, 32'd3);
        checkOutput("default_add_result", 64'(result), 64'd5);
        checkOutput("default_add_overflow", 64'(overflow), 64'd0);

        $display("[TB] iterative ops");
        runIter(OP_MULU, 32'h0001_0000, 32'h0001_0000, lat, rdy_seen);
        checkOutput("mulu_latency", 64'(lat), 64'd33);
        checkOutput("mulu_result", 64'(result), 64'd0);
        checkOutput("mulu_zero", 64'(zero), 64'd1);
        checkOutput("mulu_busy_ready", 64'(rdy_seen), 64'd0);

        runIter(OP_MULU, 32'd1234, 32'd5678, lat, rdy_seen);
        checkOutput("mulu2_result", 64'(result), 64'd7006652);

        runIter(OP_DIVU, 32'd100, 32'd7, lat, rdy_seen);
        checkOutput("divu_latency", 64'(lat), 64'd33);
        checkOutput("divu_result", 64'(result), 64'd14);
        checkOutput("divu_busy_ready", 64'(rdy_seen), 64'd0);

        runIter(OP_REMU, 32'd100, 32'd7, lat, rdy_seen);
        checkOutput("remu_result", 64'(result), 64'd2);
        checkOutput("remu_overflow", 64'(overflow), 64'd0);

        runIter(OP_DIVU, 32'd5, 32'd0, lat, rdy_seen);
        checkOutput("divu0_result", 64'(result), 64'hFFFF_FFFF);
        runIter(OP_REMU, 32'd5, 32'd0, lat, rdy_seen);
        checkOutput("remu0_result", 64'(result), 64'd5);
        checkOutput("remu0_latency", 64'(lat), 64'd33);

        $display("[TB] reset during BUSY");
        @(negedge clk);
        applyStimulus(OP_DIVU, 32'd100, 32'd7);
        @(negedge clk);
        in_valid = 1'b0;
        repeat (5) @(negedge clk);
        reset_n = 1'b0;
        @(negedge clk);
        checkOutput("midrst_out_valid", 64'(out_valid), 64'd0);
        checkOutput("midrst_result", 64'(result), 64'd0);
        checkOutput("midrst_in_ready", 64'(in_ready), 64'd1);
        reset_n = 1'b1;
        stale   = 1'b0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (out_valid) stale = 1'b1;
        end
        checkOutput("midrst_no_stale_done", 64'(stale), 64'd0);

        $display("[TB] backpressure and streaming");
        out_ready = 1'b0;
        @(negedge clk);
        applyStimulus(OP_ADD, 32'd2, 32'd3);
        @(negedge clk);
        applyStimulus(OP_AND, 32'hFF00_FF00, 32'h0FF0_0FF0);
        checkOutput("bp_valid", 64'(out_valid), 64'd1);
        checkOutput("bp_result", 64'(result), 64'd5);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            checkOutput("bp_hold_result", 64'(result), 64'd5);
            checkOutput("bp_hold_in_ready", 64'(in_ready), 64'd0);
            checkOutput("bp_hold_valid", 64'(out_valid), 64'd1);
        end
        out_ready = 1'b1;
        @(negedge clk);
        checkOutput("bp_release_result", 64'(result), 64'h0F00_0F00);
        checkOutput("bp_release_valid", 64'(out_valid), 64'd1);
        for (int i = 0; i < 4; i++) begin
            applyStimulus(OP_AND, sa[i], sb[i]);
            @(negedge clk);
            checkOutput("stream_valid", 64'(out_valid), 64'd1);
            checkOutput("stream_result", 64'(result), 64'(se[i]));
        end
        checkOutput("stream_last_zero", 64'(zero), 64'd1);
        in_valid = 1'b0;
        @(negedge clk);
        checkOutput("stream_idle", 64'(out_valid), 64'd0);

        $display("[TB] WIDTH=8 regression");
        @(negedge clk);
        in_valid8 = 1'b1;
        alu_ctrl8 = OP_MULU;
        a8        = 8'h0F;
        b8        = 8'h11;
        @(negedge clk);
        in_valid8 = 1'b0;
        a8        = 8'hAA;
        b8        = 8'h00;
        lat       = 0;
        rdy_seen  = 1'b0;
        while (!out_valid8 && lat < 100) begin
            if (in_ready8) rdy_seen = 1'b1;
            @(negedge clk);
            lat++;
        end
        checkOutput("w8_mulu_latency", 64'(lat), 64'd9);
        checkOutput("w8_mulu_result", 64'(result8), 64'hFF);
        checkOutput("w8_mulu_busy_ready", 64'(rdy_seen), 64'd0);

        @(negedge clk);
        in_valid8 = 1'b1;
        alu_ctrl8 = OP_ADD;
        a8        = 8'h7F;
        b8        = 8'h01;
        @(negedge clk);
        in_valid8 = 1'b0;
        checkOutput("w8_add_result", 64'(result8), 64'h80);
        checkOutput("w8_add_overflow", 64'(overflow8), 64'd1);
        checkOutput("w8_add_zero", 64'(zero8), 64'd0);

        @(negedge clk);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
